// File: rtl/xphm_ram_pkg.sv
// xphm_ram_pkg: shared sizing constants for the X-packet-header memory
package xphm_ram_pkg;
  localparam int XPHM_DATA_WIDTH = 64;
  localparam int XPHM_DEPTH = 1024;
  localparam int XPHM_RD_LAT = 2;
  localparam int BURST_CNT_WIDTH = 16;
endpackage

// File: rtl/xphm_ram_if.sv
// xphm_ram_if: loader write port, packet-generator read port and burst status; XPHM_PARITY_EN adds parity_err
interface xphm_ram_if import xphm_ram_pkg::*; #(
  parameter int DW = XPHM_DATA_WIDTH,
  parameter int AW = $clog2(XPHM_DEPTH)
);
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_din;
  logic rd_en;
  logic rd_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] dout;
  logic dout_vld;
  logic dout_last;
  logic busy;
  logic burst_done;
  logic [BURST_CNT_WIDTH-1:0] burst_cnt;
`ifdef XPHM_PARITY_EN
  logic parity_err;
  modport master (output wr_en, wr_addr, wr_din, rd_en, rd_last, rd_addr,
                  input dout, dout_vld, dout_last, busy, burst_done, burst_cnt, parity_err);
  modport slave (input wr_en, wr_addr, wr_din, rd_en, rd_last, rd_addr,
                 output dout, dout_vld, dout_last, busy, burst_done, burst_cnt, parity_err);
`else
  modport master (output wr_en, wr_addr, wr_din, rd_en, rd_last, rd_addr,
                  input dout, dout_vld, dout_last, busy, burst_done, burst_cnt);
  modport slave (input wr_en, wr_addr, wr_din, rd_en, rd_last, rd_addr,
                 output dout, dout_vld, dout_last, busy, burst_done, burst_cnt);
`endif
endinterface

// File: rtl/xphm_rd_pipe.sv
// xphm_rd_pipe: valid/last/data shift pipeline behind the RAM read register, plus in-flight read count
module xphm_rd_pipe #(
  parameter int W = 64,
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_en_i,
  input  logic rd_last_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic vld_o,
  output logic last_o,
  output logic busy_o
);
  localparam int CW = $clog2(RD_LAT + 1) + 1;
  logic [RD_LAT-1:0] vld_q, vld_d, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q;
  // next shift state; count goes up on accept and down on issue
  always_comb begin
    vld_d = (vld_q << 1) | RD_LAT'(rd_en_i);
    last_d = (last_q << 1) | RD_LAT'(rd_en_i & rd_last_i);
    cnt_d = cnt_q + CW'(rd_en_i) - CW'(vld_q[RD_LAT-1]);
  end
  // valid/last shift, in-flight count, and busy registered from the next count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      last_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      busy_q <= cnt_d != '0;
    end
  end
  if (RD_LAT == 1) begin : g_direct
    assign dout_o = din_i;
  end else begin : g_regs
    logic [RD_LAT-2:0][W-1:0] d_q;
    // data advances only behind a valid word so dout holds between bursts
    always_ff @(posedge clk or posedge rst) begin
      if (rst) d_q <= '0;
      else begin
        if (vld_q[0]) d_q[0] <= din_i;
        for (int k = 1; k < RD_LAT - 1; k++) if (vld_q[k]) d_q[k] <= d_q[k-1];
      end
    end
    assign dout_o = d_q[RD_LAT-2];
  end
  assign vld_o = vld_q[RD_LAT-1];
  assign last_o = last_q[RD_LAT-1];
  assign busy_o = busy_q;
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(vld_q[RD_LAT-1] && cnt_q == '0));
endmodule

// File: rtl/xphm_ram.sv
// xphm_ram: X-packet-header RAM with fixed-latency burst reads and burst accounting; XPHM_PARITY_EN adds stored even parity and parity_err
module xphm_ram import xphm_ram_pkg::*; #(
  parameter int DATA_WIDTH = XPHM_DATA_WIDTH,
  parameter int DEPTH = XPHM_DEPTH,
  parameter int RD_LAT = XPHM_RD_LAT
) (
  input logic clk,
  input logic rst,
  xphm_ram_if.slave bus
);
`ifdef XPHM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] ram_q, wr_word, dout_w;
  logic [BURST_CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic vld, last;
`ifdef XPHM_PARITY_EN
  assign wr_word = {^bus.wr_din, bus.wr_din};
`else
  assign wr_word = bus.wr_din;
`endif
  // write port; the array itself is never reset
  always_ff @(posedge clk) if (bus.wr_en) mem[bus.wr_addr] <= wr_word;
  // stage 1 read register; a same-cycle write to the same address returns the old word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_q <= '0;
    else if (bus.rd_en) ram_q <= mem[bus.rd_addr];
  end
  xphm_rd_pipe #(.W(MW), .RD_LAT(RD_LAT)) u_pipe (
    .clk(clk),
    .rst(rst),
    .rd_en_i(bus.rd_en),
    .rd_last_i(bus.rd_last),
    .din_i(ram_q),
    .dout_o(dout_w),
    .vld_o(vld),
    .last_o(last),
    .busy_o(bus.busy)
  );
  assign burst_cnt_d = burst_cnt_q + BURST_CNT_WIDTH'(vld & last);
  // completed-burst counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_cnt_q <= '0;
    else burst_cnt_q <= burst_cnt_d;
  end
  assign bus.dout = dout_w[DATA_WIDTH-1:0];
  assign bus.dout_vld = vld;
  assign bus.dout_last = last;
  assign bus.burst_done = vld & last;
  assign bus.burst_cnt = burst_cnt_q;
`ifdef XPHM_PARITY_EN
  logic perr_q, bad;
  assign bad = vld & ^dout_w;
  // sticky parity error, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else if (bad) perr_q <= 1'b1;
  end
  assign bus.parity_err = perr_q | bad;
`endif
endmodule

// File: tb/tb_xphm_ram.sv
// tb_xphm_ram: table-driven and scoreboard checks of xphm_ram reads, bookkeeping and reset
module tb_xphm_ram;
  import xphm_ram_pkg::*;
  localparam int LAT = XPHM_RD_LAT;
  typedef struct {logic [63:0] d; logic l; int c;} exp_t;
  typedef struct {logic we; logic [9:0] wa; logic [63:0] wd; logic re; logic rl; logic [9:0] ra; logic [63:0] ed;} vec_t;
  typedef struct {logic re; logic busy; logic vld;} gap_t;
  logic clk = 0;
  logic rst = 1;
  exp_t q[$];
  logic [63:0] sh [16];
  logic [15:0] exp_bc = 0;
  int pass = 0, total = 0, cyc = 0, pulses = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  xphm_ram_if b();
  xphm_ram dut(.clk(clk), .rst(rst), .bus(b));

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h, expected %h", n, a, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    b.wr_en = 0;
    b.rd_en = 0;
    b.rd_last = 0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [63:0] d);
    b.wr_en = 1;
    b.wr_addr = a;
    b.wr_din = d;
    if (a < 16) sh[a[3:0]] = d;
  endtask

  task automatic rd(input logic [9:0] a, input logic l, input logic [63:0] e);
    b.rd_en = 1;
    b.rd_addr = a;
    b.rd_last = l;
    q.push_back('{e, l, cyc});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    total++;
    if (q.size() == 0) pass++;
    else begin
      $display("FAIL drain: %0d words outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_bc = 0;
      pulses = 0;
    end else begin
      chk("burst_cnt", 64'(b.burst_cnt), 64'(exp_bc));
      if (b.dout_vld) begin
        if (b.burst_done) pulses++;
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected dout_vld: got 1, expected 0 at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("dout", b.dout, e.d);
          chk("dout_last", 64'(b.dout_last), 64'(e.l));
          chk("burst_done", 64'(b.burst_done), 64'(e.l));
          chk("latency", 64'(cyc), 64'(e.c + LAT));
          exp_bc = exp_bc + 16'(e.l);
        end
      end else chk("burst_done idle", 64'(b.burst_done), 64'd0);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t v[6];
    gap_t g[11];
    logic [0:10] gre, gbusy, gvld;
    for (int i = 0; i < 4; i++) v[i] = '{1'b0, 10'd0, 64'd0, 1'b1, i == 3, 10'(i), 64'(i + 1) * 64'h11};
    v[4] = '{1'b1, 10'd5, 64'hAA, 1'b1, 1'b0, 10'd5, 64'h55};
    v[5] = '{1'b0, 10'd0, 64'd0, 1'b1, 1'b0, 10'd5, 64'hAA};
    gre = 11'b10110001000;
    gbusy = 11'b01111100110;
    gvld = 11'b00101100010;
    for (int i = 0; i < 11; i++) g[i] = '{gre[i], gbusy[i], gvld[i]};
    b.wr_en = 0; b.wr_addr = 0; b.wr_din = 0;
    b.rd_en = 0; b.rd_last = 0; b.rd_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset dout", b.dout, 64'd0);
    chk("reset dout_vld", 64'(b.dout_vld), 64'd0);
    chk("reset dout_last", 64'(b.dout_last), 64'd0);
    chk("reset busy", 64'(b.busy), 64'd0);
    chk("reset burst_done", 64'(b.burst_done), 64'd0);
    chk("reset burst_cnt", 64'(b.burst_cnt), 64'd0);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      wr(10'(i), i < 4 ? 64'(i + 1) * 64'h11 : i == 5 ? 64'h55 : 64'hA5A5_0000_0000_0000 | 64'(i));
    end
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      if (v[i].re) rd(v[i].ra, v[i].rl, v[i].ed);
      if (v[i].we) wr(v[i].wa, v[i].wd);
    end
    drain();
    chk("burst_cnt after burst", 64'(b.burst_cnt), 64'd1);
    for (int i = 0; i < 11; i++) begin
      step();
      chk($sformatf("gap busy c%0d", i), 64'(b.busy), 64'(g[i].busy));
      chk($sformatf("gap vld c%0d", i), 64'(b.dout_vld), 64'(g[i].vld));
      if (g[i].re) rd(10'd2, 1'b0, 64'h33);
    end
    drain();
`ifdef XPHM_PARITY_EN
    step();
    chk("parity_err clear", 64'(b.parity_err), 64'd0);
    dut.mem[7][3] = ~dut.mem[7][3];
    rd(10'd7, 1'b0, sh[7] ^ 64'h8);
    step();
    step();
    chk("parity vld", 64'(b.dout_vld), 64'd1);
    chk("parity_err rise", 64'(b.parity_err), 64'd1);
    step();
    step();
    chk("parity_err sticky", 64'(b.parity_err), 64'd1);
    drain();
`endif
    step();
    rd(10'd0, 1'b0, sh[0]);
    step();
    rd(10'd1, 1'b1, sh[1]);
    step();
    chk("busy two in flight", 64'(b.busy), 64'd1);
    rst = 1;
    q.delete();
    step();
    step();
    rst = 0;
`ifdef XPHM_PARITY_EN
    chk("parity_err after rst", 64'(b.parity_err), 64'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      chk("vld after rst", 64'(b.dout_vld), 64'd0);
    end
    chk("busy after rst", 64'(b.busy), 64'd0);
    chk("burst_cnt after rst", 64'(b.burst_cnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      rd(10'(i), 1'b0, sh[i]);
    end
    drain();
    for (int i = 0; i < 65536; i++) begin
      step();
      rd(10'(i % 16), 1'b1, sh[i % 16]);
    end
    drain();
    chk("burst_cnt wrap", 64'(b.burst_cnt), 64'd0);
    chk("burst_done pulses", 64'(pulses), 64'd65536);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/xphm_ram.md
Name: xphm_ram

Overview:
- X-packet-header memory feeding the X-bus packet generator.
- The instruction/DMA loader writes header words (one word per X packet: RTM address, tag, row/column info).
- The X-bus packet generator streams the words back in bursts with rd_en/rd_last. The block returns data with a fixed read latency and forwards valid and last alongside it.
- It also provides burst bookkeeping (in-flight count, completed-burst pulse and counter) used by the control unit.

Parameters:
- DATA_WIDTH, 64, header word width; must equal `XPHM_DATA_WIDTH at instantiation.
- DEPTH, 1024, number of words; power of two; address width AW = $clog2(DEPTH).
- RD_LAT, 2, read latency in cycles from rd_en to dout_vld; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe from the loader.
- wr_addr  in  AW  write address.
- wr_din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request from the packet generator.
- rd_last  in  1  marks the final read of a burst; qualified by rd_en.
- rd_addr  in  AW  read address.
- dout  out  DATA_WIDTH  read data.
- dout_vld  out  1  dout valid.
- dout_last  out  1  dout is the last word of its burst.
- busy  out  1  at least one read is in flight.
- burst_done  out  1  one-cycle pulse, coincident with dout_vld && dout_last.
- burst_cnt  out  16  number of completed bursts since reset; wraps.

Behaviour:
- Reset values:
  - dout_vld = 0, dout_last = 0, dout = 0, busy = 0, burst_done = 0, burst_cnt = 0.
  - The pipeline valid and last bits are cleared.
  - Memory contents are not cleared.
- Reset mid-burst: in-flight reads are dropped, and no dout_vld appears after rst deasserts.
- Write: synchronous, one word per cycle. No backpressure; the writer owns address validity.
- Read pipeline:
  - rd_en at cycle t gives dout_vld = 1 at t+RD_LAT, with dout = mem[rd_addr] as sampled at t.
  - dout_last at t+RD_LAT equals rd_last && rd_en sampled at t.
  - Back-to-back rd_en every cycle is supported; throughput is 1 word/cycle.
  - Stage 1 is the RAM read register. Stages 2..RD_LAT are output registers.
  - The valid and last bits shift in lockstep with the data.
- Same-address read and write in the same cycle: read-first. The read returns the old word; the new word is visible to reads issued from the next cycle on.
- dout holds its last valid value when dout_vld = 0. Consumers must not rely on it.
- rd_last without rd_en is ignored.
- In-flight counter:
  - Width $clog2(RD_LAT+1)+1.
  - +1 when rd_en is accepted; -1 when dout_vld is issued; both in one cycle leaves it unchanged.
  - busy = counter != 0, registered so that it matches the counter each cycle.
- Burst accounting:
  - burst_done is combinationally equal to dout_vld && dout_last, both of which are registered.
  - burst_cnt increments on the cycle after burst_done and wraps 0xFFFF to 0x0000.
- There is no underflow or overflow of the in-flight counter by construction. An assertion flags a decrement at zero in simulation.

Optional Feature:
- Macro: XPHM_PARITY_EN.
- Defined:
  - Each stored word carries one extra even-parity bit, computed on write.
  - Parity is recomputed on read at stage RD_LAT.
  - Extra output parity_err (1 bit, reset 0) is sticky-set on any dout_vld word whose parity mismatches. It is cleared only by rst.
  - Data is still delivered unchanged.
- Undefined: no parity storage, no parity_err port, and the RAM is DATA_WIDTH wide.

Decomposition:
- Shared package/include holds:
  - XPHM_DATA_WIDTH and XPHM_DEPTH, which already exist in the common include.
  - XPHM_RD_LAT constant.
  - BURST_CNT_WIDTH = 16.
- One natural sub-module, xphm_rd_pipe: the parameterised valid/last/data shift pipeline with in-flight counter.
- The RAM array is inferred inline in xphm_ram as a simple dual-port block RAM with a registered output.

Test Plan:
- Write mem[0..3] = 0x11, 0x22, 0x33, 0x44. Read addr 0..3 back-to-back with rd_last on addr 3 -> dout 0x11..0x44 on consecutive cycles starting 2 cycles after the first rd_en; dout_last and burst_done only with 0x44; burst_cnt = 1 one cycle later.
- Same cycle: write addr 5 = 0xAA (old value 0x55) and read addr 5, then read addr 5 again next cycle -> first read returns 0x55, second returns 0xAA.
- Gapped reads: rd_en on cycles 0, 2, 3, 7 -> dout_vld on cycles 2, 4, 5, 9; busy high exactly on cycles 1-5 and 8-9.
- Assert rst while 2 reads are in flight -> dout_vld stays 0 after release; busy = 0, burst_cnt = 0; stored memory data is still readable afterwards.
- 65536 single-word bursts (rd_en && rd_last) -> burst_cnt wraps to 0x0000; burst_done pulses 65536 times.
- XPHM_PARITY_EN defined: force-flip one stored bit of addr 7 via backdoor, then read it -> parity_err rises with that dout_vld and stays high until rst; data is returned unmodified.
